// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared single-port instruction/data memory
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT counts down from MEM_LAT-1 to 0, so it lasts exactly MEM_LAT cycles
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic       rr_ptr;    // 0 = CPU next in line on a tie, 1 = DMA
  logic       lat_we;
  logic [3:0] cnt;
  logic       grant_dma;

  // Winner selection for the current IDLE cycle; a lone requester always wins
  always_comb begin
    grant_dma = 1'b0;
    if (dma_req && !cpu_req)
      grant_dma = 1'b1;
    else if (dma_req && cpu_req)
      grant_dma = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
  end

  // Transaction FSM; every output is a register so reset clears them immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner     <= grant_dma;
            rr_ptr    <= ~grant_dma;
            lat_we    <= grant_dma ? dma_we : cpu_we;
            mem_en    <= 1'b1;
            mem_we    <= grant_dma ? dma_we : cpu_we;
            mem_addr  <= grant_dma ? dma_addr : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            cpu_ack <= ~owner;
            dma_ack <= owner;
            state   <= RESP;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (owner)
              dma_rdata <= mem_rdata;
            else
              cpu_rdata <= mem_rdata;
            cpu_ack <= ~owner;
            dma_ack <= owner;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        a_cpu_req, a_cpu_we, a_cpu_ack, a_dma_req, a_dma_we, a_dma_ack;
  logic [9:0]  a_cpu_addr, a_dma_addr, a_mem_addr;
  logic [31:0] a_cpu_wdata, a_cpu_rdata, a_dma_wdata, a_dma_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_mem_en, a_mem_we, a_busy, a_owner;

  logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_dma_req, b_dma_we, b_dma_ack;
  logic [9:0]  b_cpu_addr, b_dma_addr, b_mem_addr;
  logic [31:0] b_cpu_wdata, b_cpu_rdata, b_dma_wdata, b_dma_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_mem_en, b_mem_we, b_busy, b_owner;

  mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(2), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .rst(rst_a),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack),
    .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
    .dma_rdata(a_dma_rdata), .dma_ack(a_dma_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(15), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .rst(rst_b),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  // Memory contents as a fixed function of address
  function automatic logic [31:0] mem_val(input logic [9:0] addr);
    return (addr == 10'h010) ? 32'hDEADBEEF : (32'hC0DE0000 | {22'd0, addr});
  endfunction

  // Memory models: read data is driven only in the cycle MEM_LAT after mem_en, garbage otherwise
  logic [31:0] a_pd [2];
  logic        a_pv [2];
  logic [31:0] b_pd [15];
  logic        b_pv [15];
  always @(posedge clk) begin
    a_pd[0] <= mem_val(a_mem_addr);
    a_pv[0] <= a_mem_en & ~a_mem_we;
    a_pd[1] <= a_pd[0];
    a_pv[1] <= a_pv[0];
    b_pd[0] <= mem_val(b_mem_addr);
    b_pv[0] <= b_mem_en & ~b_mem_we;
    for (int i = 1; i < 15; i++) begin
      b_pd[i] <= b_pd[i-1];
      b_pv[i] <= b_pv[i-1];
    end
  end
  assign a_mem_rdata = a_pv[1]  ? a_pd[1]  : 32'hBAD0BAD0;
  assign b_mem_rdata = b_pv[14] ? b_pd[14] : 32'hBAD0BAD0;

  logic both_ack_seen = 1'b0;
  always @(negedge clk) begin
    if ((a_cpu_ack && a_dma_ack) || (b_cpu_ack && b_dma_ack)) both_ack_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ack_a(output int n, output logic who);
    n = -1;
    who = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (a_cpu_ack || a_dma_ack) begin
        n = i;
        who = a_dma_ack;
        break;
      end
    end
  endtask

  task automatic wait_ack_b(output int n, output logic who);
    n = -1;
    who = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (b_cpu_ack || b_dma_ack) begin
        n = i;
        who = b_dma_ack;
        break;
      end
    end
  endtask

  initial begin
    int   n;
    logic who;
    logic quiet;

    {a_cpu_req, a_cpu_we, a_dma_req, a_dma_we} = '0;
    {b_cpu_req, b_cpu_we, b_dma_req, b_dma_we} = '0;
    a_cpu_addr = '0; a_dma_addr = '0; a_cpu_wdata = '0; a_dma_wdata = '0;
    b_cpu_addr = '0; b_dma_addr = '0; b_cpu_wdata = '0; b_dma_wdata = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) step();
    check("reset_ctrl_a", {a_mem_en, a_mem_we, a_busy, a_owner, a_cpu_ack, a_dma_ack}, 0);
    check("reset_rdata_a", a_cpu_rdata | a_dma_rdata, 0);
    check("reset_ctrl_b", {b_mem_en, b_mem_we, b_busy, b_owner, b_cpu_ack, b_dma_ack}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();

    // Reset asserted in ISSUE, WAIT, WAIT, RESP of a CPU read
    for (int k = 1; k <= 4; k++) begin
      a_cpu_addr = 10'h155; a_cpu_wdata = 32'hFFFFFFFF; a_cpu_we = 1'b0; a_cpu_req = 1'b1;
      repeat (k) step();
      check("rst_pre_busy", a_busy, 1);
      rst_a = 1'b1;
      #1;
      check("rst_outputs", {a_mem_en, a_mem_we, a_busy, a_owner, a_cpu_ack, a_dma_ack,
                            |a_mem_addr, |a_mem_wdata}, 0);
      check("rst_rdata", a_cpu_rdata, 0);
      a_cpu_req = 1'b0;
      step();
      rst_a = 1'b0;
      quiet = 1'b0;
      repeat (8) begin
        step();
        quiet = quiet | a_cpu_ack | a_dma_ack | a_busy;
      end
      check("rst_no_ack", quiet, 0);
    end

    // CPU read of 0x010, MEM_LAT=2
    a_cpu_addr = 10'h010; a_cpu_wdata = '0; a_cpu_we = 1'b0; a_cpu_req = 1'b1;
    step();
    check("rd_issue", {a_mem_en, a_mem_we, a_busy, a_owner}, 4'b1010);
    check("rd_addr", a_mem_addr, 10'h010);
    step();
    check("rd_en_c2", {a_mem_en, a_cpu_ack}, 0);
    step();
    check("rd_en_c3", {a_mem_en, a_cpu_ack}, 0);
    step();
    check("rd_ack_c4", {a_cpu_ack, a_dma_ack}, 2'b10);
    check("rd_cpu_rdata", a_cpu_rdata, 32'hDEADBEEF);
    check("rd_dma_rdata", a_dma_rdata, 0);
    a_cpu_req = 1'b0;
    step();
    check("rd_idle", {a_busy, a_cpu_ack, a_mem_en}, 0);

    // DMA write of 0x12345678 to the top address
    a_dma_addr = 10'h3FF; a_dma_wdata = 32'h12345678; a_dma_we = 1'b1; a_dma_req = 1'b1;
    step();
    check("wr_issue", {a_mem_en, a_mem_we, a_busy, a_owner}, 4'b1111);
    check("wr_addr", a_mem_addr, 10'h3FF);
    check("wr_wdata", a_mem_wdata, 32'h12345678);
    step();
    check("wr_ack_c2", {a_cpu_ack, a_dma_ack, a_mem_en}, 3'b010);
    a_dma_req = 1'b0; a_dma_we = 1'b0;
    step();
    check("wr_cpu_rdata_held", a_cpu_rdata, 32'hDEADBEEF);
    check("wr_dma_rdata_held", a_dma_rdata, 0);

    // Round robin with both requesters held
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    step();
    a_cpu_addr = 10'h001; a_dma_addr = 10'h002; a_cpu_req = 1'b1; a_dma_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ack_a(n, who);
      check("rr_who", who, g[0]);
      check("rr_owner", a_owner, g[0]);
      check("rr_lat", n, (g == 0) ? 4 : 5);
    end
    a_cpu_req = 1'b0; a_dma_req = 1'b0;
    step();
    check("rr_cpu_rdata", a_cpu_rdata, 32'hC0DE0001);
    check("rr_dma_rdata", a_dma_rdata, 32'hC0DE0002);

    // Fixed priority, both writing, CPU wins until it lets go
    b_cpu_addr = 10'h005; b_cpu_wdata = 32'h55550005; b_cpu_we = 1'b1; b_cpu_req = 1'b1;
    b_dma_addr = 10'h006; b_dma_wdata = 32'h66660006; b_dma_we = 1'b1; b_dma_req = 1'b1;
    step();
    check("fp_issue", {b_mem_en, b_mem_we, b_owner}, 3'b110);
    check("fp_wdata", b_mem_wdata, 32'h55550005);
    wait_ack_b(n, who);
    check("fp_who0", who, 0);
    check("fp_lat0", n, 1);
    wait_ack_b(n, who);
    check("fp_who1", who, 0);
    check("fp_lat1", n, 3);
    b_cpu_req = 1'b0; b_cpu_we = 1'b0;
    wait_ack_b(n, who);
    check("fp_who2", who, 1);
    check("fp_owner2", b_owner, 1);
    check("fp_lat2", n, 3);
    b_dma_req = 1'b0; b_dma_we = 1'b0;
    step();

    // MEM_LAT=15 read, then a read aborted by reset in its 5th WAIT cycle
    b_cpu_addr = 10'h007; b_cpu_req = 1'b1;
    wait_ack_b(n, who);
    check("l15_lat", n, 17);
    check("l15_rdata", b_cpu_rdata, 32'hC0DE0007);
    b_cpu_req = 1'b0;
    step();
    b_cpu_addr = 10'h008; b_cpu_req = 1'b1;
    repeat (6) step();
    check("abort_busy", {b_busy, b_cpu_ack}, 2'b10);
    rst_b = 1'b1;
    #1;
    check("abort_rdata", b_cpu_rdata, 0);
    check("abort_busy_clr", b_busy, 0);
    b_cpu_req = 1'b0;
    step();
    rst_b = 1'b0;
    quiet = 1'b0;
    repeat (20) begin
      step();
      quiet = quiet | b_cpu_ack | b_dma_ack;
    end
    check("abort_no_ack", quiet, 0);
    b_dma_addr = 10'h00A; b_dma_we = 1'b0; b_dma_req = 1'b1;
    wait_ack_b(n, who);
    check("post_abort_who", who, 1);
    check("post_abort_lat", n, 17);
    check("post_abort_dma_rdata", b_dma_rdata, 32'hC0DE000A);
    check("post_abort_cpu_rdata", b_cpu_rdata, 0);
    b_dma_req = 1'b0;
    step();

    check("ack_exclusive", both_ack_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
